// File: rtl/casrec_pkg.sv
// Shared types and constants for the cassette recorder.
package casrec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        RECORD = 2'd2
    } state_e;

    localparam logic [7:0] LEADER_BYTE = 8'h55;
    localparam int PERIOD_W = 16;
    localparam int DEGLITCH_LEN = 16;

endpackage

// File: rtl/casrec_period_meter.sv
// Cassette input conditioning, full-cycle period measurement and gap detect.
// Define CASREC_DEGLITCH_EN to require 16 stable clocks before cout is accepted.
module casrec_period_meter
    import casrec_pkg::*;
#(
    parameter int BIT_THRESH = 2500,
    parameter int MIN_PERIOD = 800,
    parameter int GAP_CYCLES = 12000
) (
    input  logic clk,
    input  logic reset,
    input  logic cout,
    input  logic disarm,
    output logic bit_valid,
    output logic bit_value,
    output logic gap
);

    localparam logic [PERIOD_W-1:0] BIT_TH = PERIOD_W'(BIT_THRESH);
    localparam logic [PERIOD_W-1:0] MIN_TH = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] GAP_TH = PERIOD_W'(GAP_CYCLES - 1);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic prev_q;
    logic edge_det;
    logic armed_q, armed_d;
    logic [PERIOD_W-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= cout;
            sync2_q <= sync1_q;
        end
    end

`ifdef CASREC_DEGLITCH_EN
    localparam int DG_W = $clog2(DEGLITCH_LEN);

    logic [DG_W-1:0] stab_q, stab_d;
    logic level_q, level_d;

    always_comb begin
        stab_d  = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (stab_q == DG_W'(DEGLITCH_LEN - 1)) begin
                level_d = sync2_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stab_q  <= '0;
            level_q <= 1'b0;
        end else begin
            stab_q  <= stab_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    assign edge_det = level & ~prev_q;

    // An edge only yields a bit when a previous edge opened the measurement.
    always_comb begin
        count_d   = count_q;
        armed_d   = armed_q;
        bit_valid = 1'b0;
        gap       = 1'b0;
        bit_value = (count_q < BIT_TH);
        if (edge_det) begin
            count_d   = '0;
            armed_d   = 1'b1;
            bit_valid = armed_q && (count_q >= MIN_TH);
        end else begin
            if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
            if (count_q == GAP_TH) begin
                gap     = 1'b1;
                armed_d = 1'b0;
            end
        end
        if (disarm) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            count_q <= '0;
        end else begin
            prev_q  <= level;
            armed_q <= armed_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cassette_rec.sv
// MC-10 cassette recorder: decodes cout into bytes aligned on the 0x55 leader
// and writes them to SDRAM over a req/ack port.
module cassette_rec
    import casrec_pkg::*;
#(
    parameter int          CLK_HZ     = 4000000,
    parameter int          BIT_THRESH = 2500,
    parameter int          MIN_PERIOD = 800,
    parameter int          GAP_CYCLES = 12000,
    parameter logic [24:0] BASE_ADDR  = 25'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cout,
    input  logic        rec_en,
    output logic        wr_req,
    input  logic        wr_ack,
    output logic [24:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [24:0] byte_count,
    output logic        overrun,
    output logic [1:0]  status
);

    localparam int GAP_LIM = (CLK_HZ > 0) ? GAP_CYCLES : 1;

    state_e state_q, state_d;
    logic [7:0]  win_q, win_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic        wr_req_q, wr_req_d;
    logic [24:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [24:0] byte_count_q, byte_count_d;
    logic        overrun_q, overrun_d;

    logic       bit_valid;
    logic       bit_value;
    logic       gap;
    logic [7:0] shifted;
    logic       emit;
    logic [7:0] emit_byte;
    logic       ack;

    casrec_period_meter #(
        .BIT_THRESH (BIT_THRESH),
        .MIN_PERIOD (MIN_PERIOD),
        .GAP_CYCLES (GAP_LIM)
    ) u_meter (
        .clk       (clk),
        .reset     (reset),
        .cout      (cout),
        .disarm    (state_q == IDLE),
        .bit_valid (bit_valid),
        .bit_value (bit_value),
        .gap       (gap)
    );

    assign shifted = {bit_value, win_q[7:1]};

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        bcnt_d    = bcnt_q;
        emit      = 1'b0;
        emit_byte = shifted;
        unique case (state_q)
            IDLE: begin
                if (rec_en) begin
                    state_d = HUNT;
                end
            end
            HUNT: begin
                if (bit_valid) begin
                    win_d = shifted;
                    if (shifted == LEADER_BYTE) begin
                        emit    = 1'b1;
                        bcnt_d  = '0;
                        state_d = RECORD;
                    end
                end
            end
            RECORD: begin
                if (gap) begin
                    win_d   = '0;
                    bcnt_d  = '0;
                    state_d = HUNT;
                end else if (bit_valid) begin
                    win_d  = shifted;
                    bcnt_d = bcnt_q + 3'd1;
                    emit   = (bcnt_q == 3'd7);
                end
            end
            default: state_d = IDLE;
        endcase
        // Disable beats any byte completing in the same cycle.
        if (!rec_en) begin
            state_d = IDLE;
            win_d   = '0;
            bcnt_d  = '0;
            emit    = 1'b0;
        end
    end

    assign ack = wr_req_q & wr_ack;

    always_comb begin
        wr_req_d     = wr_req_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        byte_count_d = byte_count_q;
        overrun_d    = overrun_q;
        if (ack) begin
            wr_req_d     = 1'b0;
            wr_addr_d    = wr_addr_q + 25'd1;
            byte_count_d = byte_count_q + 25'd1;
        end
        // The holding register frees up in the ack cycle itself.
        if (emit) begin
            if (!wr_req_q || ack) begin
                wr_data_d = emit_byte;
                wr_req_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (state_q == IDLE && rec_en) begin
            wr_addr_d    = BASE_ADDR;
            byte_count_d = '0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            win_q        <= '0;
            bcnt_q       <= '0;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            wr_data_q    <= '0;
            byte_count_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            bcnt_q       <= bcnt_d;
            wr_req_q     <= wr_req_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            byte_count_q <= byte_count_d;
            overrun_q    <= overrun_d;
        end
    end

    assign wr_req     = wr_req_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign byte_count = byte_count_q;
    assign overrun    = overrun_q;
    assign status     = state_q;

endmodule

// File: doc/cassette_rec.md
Name: cassette_rec

Overview:
- Recorder counterpart of the existing tape player `cassette`. The player turns stored `.c10` bytes into the `cin` bit; this block does the reverse.
- Watches the MC-10 cassette output bit and measures the full-cycle period between rising edges.
- Classifies each cycle as a 0 (1200 Hz) or a 1 (2400 Hz), aligns bytes on the 0x55 leader, and writes the bytes into SDRAM through a req/ack port so they can be saved as a `.c10` image.
- Sits in the `clk_4` domain beside `cassette`; is enabled by an OSD toggle.

Parameters:
- CLK_HZ, 4000000, clock frequency; documentation only, all thresholds are given in clocks.
- BIT_THRESH, 2500, full-cycle period in clocks; below it the bit is 1, at or above it the bit is 0.
- MIN_PERIOD, 800, periods shorter than this are noise: the bit is discarded and the counter restarts.
- GAP_CYCLES, 12000, no rising edge for this many clocks means a gap (silence).
- BASE_ADDR, 25'h0, SDRAM byte address of the first recorded byte.

Ports:
- clk  in  1  recorder clock (clk_4)
- reset  in  1  synchronous, active-high
- cout  in  1  MC-10 cassette output bit; asynchronous
- rec_en  in  1  record enable (OSD toggle)
- wr_req  out  1  write request; held until acked
- wr_ack  in  1  one-cycle acknowledge from the SDRAM arbiter
- wr_addr  out  25  write address, valid while wr_req=1
- wr_data  out  8  write data, valid while wr_req=1
- byte_count  out  25  number of bytes acked since the session started
- overrun  out  1  sticky: a byte was dropped because a write was still pending
- status  out  2  0=IDLE 1=HUNT 2=RECORD

Behaviour:
- Reset values: wr_req=0, wr_addr=BASE_ADDR, wr_data=0, byte_count=0, overrun=0, status=IDLE. Internal shift register and period counter are also cleared.
- Input conditioning: `cout` passes through a 2-flop synchronizer. A rising edge is detected on the synchronized bit, giving a one-cycle `edge` pulse 3 clocks after the pin toggles.
- Period counter (16 bits):
  - Cleared on `edge`; otherwise increments, saturating at 16'hFFFF.
  - On `edge` with count < MIN_PERIOD: no bit is produced.
  - On `edge` with count ≥ MIN_PERIOD: emit `bit_valid` the same cycle, with bit = (count < BIT_THRESH).
  - The first edge after IDLE, or after a gap, only arms the counter and produces no bit.
  - `gap` pulses once when count reaches GAP_CYCLES. It does not repeat until another edge occurs.
- State machine:
  - IDLE: entered on reset or when rec_en=0. Leaving IDLE when rec_en rises: clear wr_addr to BASE_ADDR, byte_count=0, overrun=0, then go to HUNT.
  - HUNT: each bit is shifted into an 8-bit window, LSB first (new bit enters at [7], shifting right). When the window equals 8'h55, emit 0x55 as the first byte, clear the bit counter and go to RECORD.
  - RECORD: assemble 8 bits LSB first. On the 8th bit, emit the byte and reset the bit counter. On `gap`, discard any partial bits (0–7) and go to HUNT.
  - rec_en falling from any state: go to IDLE next cycle and discard partial bits. A pending wr_req is still completed.
- Byte emit: one-entry holding register.
  - If wr_req=0: load wr_data and set wr_req=1 in the next cycle, so latency is 1 clock from the completing bit.
  - If wr_req=1 and no wr_ack in that same cycle: drop the byte and set overrun.
  - If emit and wr_ack coincide: accept the new byte, with wr_addr already advanced.
- On wr_ack: clear wr_req; wr_addr+1 and byte_count+1 in the same cycle. wr_addr wraps at 2^25, and byte_count wraps with it.
- Reset mid-operation wins over everything: wr_req drops the same clock edge and nothing further is written.

Optional Feature:
- Macro CASREC_DEGLITCH_EN. When defined, the synchronized `cout` only updates after it has been stable for 16 consecutive clocks. This adds 16 clocks of edge latency and rejects pulses of 15 clocks or fewer.
- When the macro is not defined, the bare 2-flop synchronizer is used.

Decomposition:
- Package `casrec_pkg`:
  - state enum: IDLE, HUNT, RECORD
  - LEADER_BYTE = 8'h55
  - PERIOD_W = 16
  - DEGLITCH_LEN = 16
- Sub-module `casrec_period_meter`: synchronizer, optional deglitch, edge detect, period counter and gap detect. Outputs `bit_valid`, `bit`, `gap`.

Test Plan:
- Basic recording: rec_en=1, drive bit pattern 0x55,0x55,0x3C (periods 1667 for 1, 3333 for 0) → writes 55,55,3C at addresses 0,1,2; byte_count=3; status=RECORD.
- Misaligned start: send 3 stray 0-bits, then 0x55,0xA5 → first write is 0x55, then 0xA5. The stray bits are never written.
- Gap handling: send 0x12, then 4 bits, then hold cout low for 12000 clocks → one write of 0x12; status returns to HUNT; the partial bits are discarded.
- Overrun: hold wr_ack=0 while 2 bytes complete → only the first byte is presented; overrun=1. Ack it → byte_count=1.
- Noise and disable: a 500-clock period is ignored (no bit). Dropping rec_en mid-byte → status=IDLE next cycle; the pending wr_req completes after ack.
- Reset during wr_req=1 → wr_req=0, wr_addr=BASE_ADDR, byte_count=0 on the next clock.
